// File: rtl/seq_shift_pkg.sv
// Shared encodings and helpers for the sequential shifter.
package seq_shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    // Bit of the original operand that ends up as the last bit shifted out.
    function automatic int unsigned carry_idx(input op_e op, input int unsigned shamt,
                                              input int unsigned width);
        if (shamt == 0) return 0;
        if (op == OP_SLL) return width - shamt;
        return shamt - 1;
    endfunction

endpackage

// File: rtl/seq_shift_unit_if.sv
// Request/result bundle of seq_shift_unit; master drives requests, slave is the unit.
interface seq_shift_unit_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned AMT_W = $clog2(WIDTH);

    logic             SHIFT_EN;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             SRC_SEL;
    logic [1:0]       ALU_FUN;
    logic [AMT_W-1:0] SHAMT;
    logic [WIDTH-1:0] SHIFT_OUT;
    logic             SHIFT_Flag;
    logic             OUT_READY;
    logic             CARRY_OUT;
    logic             ZERO;

    modport master (
        output SHIFT_EN, IN_VALID, A, B, SRC_SEL, ALU_FUN, SHAMT, OUT_READY,
        input  IN_READY, SHIFT_OUT, SHIFT_Flag, CARRY_OUT, ZERO
    );

    modport slave (
        input  SHIFT_EN, IN_VALID, A, B, SRC_SEL, ALU_FUN, SHAMT, OUT_READY,
        output IN_READY, SHIFT_OUT, SHIFT_Flag, CARRY_OUT, ZERO
    );

endinterface

// File: rtl/shift_step.sv
// Combinational single-step shifter by 0..STEP positions.
// Rotate datapath only exists when SEQ_SHIFT_ROTATE_EN is defined.
module shift_step
    import seq_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic [AMT_W-1:0] i_k,
    input  op_e              i_op,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_val
);

    logic [WIDTH-1:0] w_fill_mask;

    always_comb begin
        w_fill_mask = i_fill ? ~({WIDTH{1'b1}} >> i_k) : '0;
        case (i_op)
            OP_SLL:  o_val = i_val << i_k;
            OP_SRL:  o_val = i_val >> i_k;
            OP_SRA:  o_val = (i_val >> i_k) | w_fill_mask;
`ifdef SEQ_SHIFT_ROTATE_EN
            OP_ROR:  o_val = (i_val >> i_k) | (i_val << (WIDTH - 32'(i_k)));
`endif
            default: o_val = i_val;
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: STEP bit positions per cycle, valid/ready in and out.
// Define SEQ_SHIFT_ROTATE_EN to enable rotate-right on ALU_FUN=11.
module seq_shift_unit
    import seq_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEP  = 1
) (
    input logic             CLK,
    input logic             RST,
    seq_shift_unit_if.slave bus
);

    localparam int unsigned      AMT_W    = $clog2(WIDTH);
    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_work, w_work_d;
    logic [AMT_W-1:0] r_rem, w_rem_d;
    op_e              r_op, w_op_d;
    logic             r_fill, w_fill_d;
    logic             r_cpend, w_cpend_d;
    logic [WIDTH-1:0] r_out, w_out_d;
    logic             r_carry, w_carry_d;
    logic             r_zero, w_zero_d;

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_operand;
    op_e              w_req_op;
    logic [AMT_W-1:0] w_cidx;
    logic [AMT_W-1:0] w_k;
    logic [WIDTH-1:0] w_step_val;

    assign w_in_ready = bus.SHIFT_EN &
                        ((r_state == ST_IDLE) | ((r_state == ST_DONE) & bus.OUT_READY));
    assign w_accept   = bus.IN_VALID & w_in_ready;
    assign w_operand  = bus.SRC_SEL ? bus.B : bus.A;
    assign w_req_op   = op_e'(bus.ALU_FUN);
    assign w_cidx     = AMT_W'(carry_idx(w_req_op, 32'(bus.SHAMT), WIDTH));
    assign w_k        = (r_rem < STEP_AMT) ? r_rem : STEP_AMT;

    shift_step #(
        .WIDTH(WIDTH),
        .AMT_W(AMT_W)
    ) u_step (
        .i_val (r_work),
        .i_k   (w_k),
        .i_op  (r_op),
        .i_fill(r_fill),
        .o_val (w_step_val)
    );

    always_comb begin
        w_state_d = r_state;
        w_work_d  = r_work;
        w_rem_d   = r_rem;
        w_op_d    = r_op;
        w_fill_d  = r_fill;
        w_cpend_d = r_cpend;
        w_out_d   = r_out;
        w_carry_d = r_carry;
        w_zero_d  = r_zero;

        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_op_d    = w_req_op;
                    w_fill_d  = w_operand[WIDTH-1];
                    w_cpend_d = w_operand[w_cidx];
`ifndef SEQ_SHIFT_ROTATE_EN
                    if (w_req_op == OP_ROR) begin
                        w_out_d   = '0;
                        w_zero_d  = 1'b1;
                        w_carry_d = 1'b0;
                        w_state_d = ST_DONE;
                    end else
`endif
                    if (bus.SHAMT == '0) begin
                        w_out_d   = w_operand;
                        w_zero_d  = (w_operand == '0);
                        w_carry_d = 1'b0;
                        w_state_d = ST_DONE;
                    end else begin
                        w_work_d  = w_operand;
                        w_rem_d   = bus.SHAMT;
                        w_state_d = ST_SHIFT;
                    end
                end else if (r_state == ST_DONE && bus.OUT_READY) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_work_d = w_step_val;
                w_rem_d  = r_rem - w_k;
                if (w_rem_d == '0) begin
                    w_out_d   = w_step_val;
                    w_zero_d  = (w_step_val == '0);
                    w_carry_d = r_cpend;
                    w_state_d = ST_DONE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_rem   <= '0;
            r_op    <= OP_SLL;
            r_fill  <= 1'b0;
            r_cpend <= 1'b0;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (bus.SHIFT_EN) begin
            r_state <= w_state_d;
            r_work  <= w_work_d;
            r_rem   <= w_rem_d;
            r_op    <= w_op_d;
            r_fill  <= w_fill_d;
            r_cpend <= w_cpend_d;
            r_out   <= w_out_d;
            r_carry <= w_carry_d;
            r_zero  <= w_zero_d;
        end
    end

    assign bus.IN_READY   = w_in_ready;
    assign bus.SHIFT_OUT  = r_out;
    assign bus.SHIFT_Flag = (r_state == ST_DONE);
    assign bus.CARRY_OUT  = r_carry;
    assign bus.ZERO       = r_zero;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit at WIDTH=16, STEP=4.
module tb_seq_shift_unit;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned STEP  = 4;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    seq_shift_unit_if #(.WIDTH(WIDTH)) bus ();

    seq_shift_unit #(
        .WIDTH(WIDTH),
        .STEP (STEP)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic sel, input logic [15:0] a, input logic [15:0] b,
                             input logic [1:0] fun, input logic [3:0] amt);
        bus.IN_VALID = 1'b1;
        bus.SRC_SEL  = sel;
        bus.A        = a;
        bus.B        = b;
        bus.ALU_FUN  = fun;
        bus.SHAMT    = amt;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.IN_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check({tag, " ready"}, 32'(bus.IN_READY), 1);
    endtask

    // Latency counts rising edges from the accept edge up to the one raising SHIFT_Flag.
    task automatic run_op(input string tag, input logic sel, input logic [15:0] a,
                          input logic [15:0] b, input logic [1:0] fun, input logic [3:0] amt,
                          input int stall, input logic [15:0] exp_out, input logic exp_c,
                          input int exp_lat);
        int lat;
        @(negedge CLK);
        drive_req(sel, a, b, fun, amt);
        bus.OUT_READY = 1'b0;
        wait_ready(tag);
        @(posedge CLK);
        lat = 1;
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        while (!bus.SHIFT_Flag && lat < 64) begin
            bus.SHIFT_EN = !(stall > 0 && lat < 1 + stall);
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end
        bus.SHIFT_EN = 1'b1;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " out"},     32'(bus.SHIFT_OUT), 32'(exp_out));
        check({tag, " carry"},   32'(bus.CARRY_OUT), 32'(exp_c));
        check({tag, " zero"},    32'(bus.ZERO), 32'(exp_out == 16'h0000));
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        bus.OUT_READY = 1'b0;
        check({tag, " flag drop"}, 32'(bus.SHIFT_Flag), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RST           = 1'b0;
        bus.SHIFT_EN  = 1'b1;
        bus.OUT_READY = 1'b0;
        drive_req(1'b0, 16'h0, 16'h0, 2'b00, 4'd0);
        bus.IN_VALID  = 1'b0;
        #1;
        check("reset out",   32'(bus.SHIFT_OUT), 0);
        check("reset flag",  32'(bus.SHIFT_Flag), 0);
        check("reset carry", 32'(bus.CARRY_OUT), 0);
        check("reset zero",  32'(bus.ZERO), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        check("idle ready", 32'(bus.IN_READY), 1);

        //     tag         sel   A         B         fun    amt  stall out       c     lat
        run_op("sra",      1'b0, 16'h8001, 16'h0000, 2'b10, 4'd5,  0, 16'hFC00, 1'b0, 3);
        run_op("sll_b",    1'b1, 16'hFFFF, 16'h01F1, 2'b00, 4'd8,  0, 16'hF100, 1'b1, 3);
        run_op("srl15",    1'b0, 16'hFFFF, 16'h0000, 2'b01, 4'd15, 0, 16'h0001, 1'b1, 5);
        run_op("zero_amt", 1'b0, 16'hABCD, 16'h1111, 2'b00, 4'd0,  0, 16'hABCD, 1'b0, 1);
        run_op("srl_zero", 1'b0, 16'h00F0, 16'h0000, 2'b01, 4'd8,  0, 16'h0000, 1'b1, 3);
        run_op("sll15",    1'b0, 16'h0001, 16'h0000, 2'b00, 4'd15, 0, 16'h8000, 1'b0, 5);
`ifdef SEQ_SHIFT_ROTATE_EN
        run_op("ror",      1'b0, 16'h0003, 16'h0000, 2'b11, 4'd1,  0, 16'h8001, 1'b1, 2);
`else
        run_op("ror_off",  1'b0, 16'h0003, 16'h0000, 2'b11, 4'd1,  0, 16'h0000, 1'b0, 1);
`endif
        run_op("sra_stall", 1'b0, 16'h8001, 16'h0000, 2'b10, 4'd5, 2, 16'hFC00, 1'b0, 5);

        // Back-pressure: hold the result in DONE while a new request waits.
        @(negedge CLK);
        drive_req(1'b0, 16'h0F0F, 16'h0000, 2'b01, 4'd4);
        wait_ready("bp");
        @(posedge CLK);
        @(negedge CLK);
        drive_req(1'b0, 16'h1234, 16'h0000, 2'b00, 4'd0);
        n = 0;
        while (!bus.SHIFT_Flag && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("bp out", 32'(bus.SHIFT_OUT), 32'h00F0);
        check("bp carry", 32'(bus.CARRY_OUT), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("bp hold flag",  32'(bus.SHIFT_Flag), 1);
            check("bp hold out",   32'(bus.SHIFT_OUT), 32'h00F0);
            check("bp hold ready", 32'(bus.IN_READY), 0);
        end
        bus.OUT_READY = 1'b1;
        #1;
        check("bp release ready", 32'(bus.IN_READY), 1);
        @(posedge CLK);
        @(negedge CLK);
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        check("b2b flag",  32'(bus.SHIFT_Flag), 1);
        check("b2b out",   32'(bus.SHIFT_OUT), 32'h1234);
        check("b2b carry", 32'(bus.CARRY_OUT), 0);
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        bus.OUT_READY = 1'b0;

        // Reset in the middle of a long shift.
        drive_req(1'b0, 16'hFFFF, 16'h0000, 2'b01, 4'd15);
        wait_ready("rst");
        @(posedge CLK);
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        #1 RST = 1'b0;
        #1;
        check("rst out",   32'(bus.SHIFT_OUT), 0);
        check("rst flag",  32'(bus.SHIFT_Flag), 0);
        check("rst carry", 32'(bus.CARRY_OUT), 0);
        check("rst zero",  32'(bus.ZERO), 0);
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check("rst stale flag", 32'(bus.SHIFT_Flag), 0);
        end
        check("rst idle ready", 32'(bus.IN_READY), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
